// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam int          CNT_W       = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: small synchronous FIFO of {pc, instr} with flush.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     wdata,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: pc, memory request FSM and redirect handling.
// Optional FETCH_ALIGN_CHK_EN adds a sticky misaligned-redirect fault that halts fetch.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic        fetch_fault
`endif
);
  fetch_state_t     state, state_nxt;
  logic [31:0]      pc, req_addr, tgt_pc;
  logic             fault, misalign, accept, push, pop, can_issue;
  logic             buf_empty, buf_full_unused;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     wentry, hentry;

`ifdef FETCH_ALIGN_CHK_EN
  assign tgt_pc   = redirect_pc;
  assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        fault <= 1'b0;
    else if (misalign) fault <= 1'b1;
  end
  assign fetch_fault = fault;
`else
  logic [1:0] unused_pc_lsb;
  assign unused_pc_lsb = redirect_pc[1:0];
  assign tgt_pc        = {redirect_pc[31:2], 2'b00};
  assign misalign      = 1'b0;
  assign fault         = 1'b0;
`endif

  // No request is ever outstanding in REQ, so occupancy alone gates issue.
  assign can_issue = (buf_count < CNT_W'(BUF_DEPTH));
  assign accept    = imem_req && imem_ack;
  assign push      = accept && !redirect && (state != DROP);
  assign pop       = instr_valid && !stall;
  assign wentry    = '{pc: imem_addr, instr: imem_rdata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fault) state_nxt = REQ;
      REQ:     if (imem_req && !imem_ack) state_nxt = redirect ? DROP : WAIT;
      WAIT:    if (imem_ack) state_nxt = REQ;
               else if (redirect) state_nxt = DROP;
      DROP:    if (imem_ack) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (misalign) state_nxt = IDLE;
  end

  // WAIT/DROP replay the latched address since pc may already hold a redirect target.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    unique case (state)
      REQ:        imem_req = can_issue;
      WAIT, DROP: begin
        imem_req  = 1'b1;
        imem_addr = req_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_VECTOR;
      req_addr <= RESET_VECTOR;
    end else begin
      if (state == REQ && imem_req) req_addr <= pc;
      if (redirect)                         pc <= tgt_pc;
      else if (accept && state != DROP)     pc <= pc + INSTR_BYTES;
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (redirect),
    .rdata (hentry),
    .full  (buf_full_unused),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign instr_valid = !buf_empty;
  assign instr       = buf_empty ? '0 : hentry.instr;
  assign instr_pc    = buf_empty ? '0 : hentry.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a queue-based reference model.
module tb_fetch_ctrl;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, redirect, stall, instr_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
`ifdef FETCH_ALIGN_CHK_EN
  logic        fetch_fault;
`endif

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_VECTOR(RV), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_ALIGN_CHK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction
  assign imem_rdata = memfn(imem_addr);

  // Memory responder: acks after ack_delay (or random 0..3) cycles of a held request.
  int ack_delay = 0;
  bit rand_ack = 0;
  bit pend = 0;
  int wcnt = 0, dly = 0;
  always @(posedge clk) begin
    #1;
    if (reset && imem_req) begin
      if (pend) wcnt++;
      else begin
        wcnt = 0;
        dly  = rand_ack ? int'($urandom_range(0, 3)) : ack_delay;
      end
      imem_ack = (wcnt >= dly);
      pend     = !imem_ack;
    end else begin
      imem_ack = 1'b0;
      pend     = 1'b0;
    end
  end

  // Reference model: expected buffer contents as a queue plus next fetch address.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  logic [31:0] m_fpc, m_out_addr, m_cur, m_tgt;
  bit          m_out_pend, m_out_drop, m_halted, m_exp_req, m_mis;
  int          m_since;

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      m_fpc = RV; m_out_pend = 0; m_out_drop = 0; m_halted = 0; m_since = 0;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RV ||
          instr !== 32'h0 || instr_pc !== 32'h0) begin
        errors++;
        $display("FAIL mon_reset: req=%b addr=%h valid=%b instr=%h pc=%h, required 0/%h/0/0/0",
                 imem_req, imem_addr, instr_valid, instr, instr_pc, RV);
      end
    end else begin
      checks++;
      if (instr_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL mon_valid: got %b required %b", instr_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (instr_pc !== q[0].pc || instr !== q[0].ins) begin
          errors++;
          $display("FAIL mon_head: got pc=%h instr=%h required pc=%h instr=%h",
                   instr_pc, instr, q[0].pc, q[0].ins);
        end
      end
      if (m_out_pend) begin
        m_exp_req = 1'b1; m_cur = m_out_addr;
      end else begin
        m_exp_req = (m_since >= 1) && !m_halted && (q.size() < DEPTH);
        m_cur = m_fpc;
      end
      checks++;
      if (imem_req !== m_exp_req || (m_exp_req && imem_addr !== m_cur)) begin
        errors++;
        $display("FAIL mon_req: got req=%b addr=%h required req=%b addr=%h",
                 imem_req, imem_addr, m_exp_req, m_cur);
      end
`ifdef FETCH_ALIGN_CHK_EN
      checks++;
      if (fetch_fault !== m_halted) begin
        errors++;
        $display("FAIL mon_fault: got %b required %b", fetch_fault, m_halted);
      end
      m_mis = redirect && (redirect_pc[1:0] != 2'b00);
      m_tgt = redirect_pc;
`else
      m_mis = 1'b0;
      m_tgt = redirect_pc & ~32'h3;
`endif
      if (redirect) begin
        q.delete();
        if (m_mis) begin
          m_halted = 1'b1; m_out_pend = 1'b0;
        end else begin
          m_fpc = m_tgt;
          if (m_exp_req && !imem_ack) begin
            m_out_pend = 1'b1; m_out_addr = m_cur; m_out_drop = 1'b1;
          end else m_out_pend = 1'b0;
        end
      end else begin
        if (q.size() != 0 && !stall) void'(q.pop_front());
        if (m_exp_req && imem_ack) begin
          if (!(m_out_pend && m_out_drop)) begin
            q.push_back('{m_cur, memfn(m_cur)});
            m_fpc = m_cur + 32'd4;
          end
          m_out_pend = 1'b0;
        end else if (m_exp_req && !m_out_pend) begin
          m_out_pend = 1'b1; m_out_addr = m_cur; m_out_drop = 1'b0;
        end
      end
      m_since++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0; redirect = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    ack_delay = 0; rand_ack = 0; stall = 1'b0;
    do_reset();
    repeat (5) @(posedge clk);
    #2 stall = 1'b1; ack_delay = 3;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
    checks++;
    if (imem_addr !== RV) begin errors++; $display("FAIL rst_addr: got %h required %h", imem_addr, RV); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", instr_valid); end
    checks++;
    if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h required 0", instr); end
    checks++;
    if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", instr_pc); end
    @(posedge clk); #2 reset = 1'b1; stall = 1'b0;
  endtask

  task automatic test_stream();
    ack_delay = 0; rand_ack = 0; stall = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (k == 0 ? (imem_req !== 1'b0) : (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1)))) begin
        errors++;
        $display("FAIL stream_addr k=%0d: got req=%b addr=%h required req=%b addr=%h",
                 k, imem_req, imem_addr, k != 0, 32'(4 * (k - 1)));
      end
      checks++;
      if (k < 2 ? (instr_valid !== 1'b0)
                : (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (k - 2)) || instr !== memfn(32'(4 * (k - 2))))) begin
        errors++;
        $display("FAIL stream_instr k=%0d: got valid=%b pc=%h required valid=%b pc=%h",
                 k, instr_valid, instr_pc, k >= 2, 32'(4 * (k - 2)));
      end
    end
  endtask

  task automatic test_wait();
    ack_delay = 3; rand_ack = 0; stall = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          errors++;
          $display("FAIL wait_hold k=%0d: got req=%b addr=%h required 1/00000000", k, imem_req, imem_addr);
        end
      end
      if (k == 5) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== memfn(32'h0)) begin
          errors++;
          $display("FAIL wait_data: got valid=%b pc=%h instr=%h required 1/0/%h",
                   instr_valid, instr_pc, instr, memfn(32'h0));
        end
      end
    end
  endtask

  task automatic test_stall();
    int nreq;
    ack_delay = 0; rand_ack = 0; stall = 1'b1;
    do_reset();
    nreq = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (imem_req && imem_ack) nreq++;
    end
    checks++;
    if (nreq != DEPTH) begin errors++; $display("FAIL stall_reqs: got %0d required %0d", nreq, DEPTH); end
    @(posedge clk); #2 stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== memfn(32'(4 * k))) begin
        errors++;
        $display("FAIL stall_drain k=%0d: got valid=%b pc=%h required 1/%h", k, instr_valid, instr_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    ack_delay = 3; rand_ack = 0; stall = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    @(posedge clk); #2 redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(posedge clk); #2 redirect = 1'b0;
    for (int k = 3; k < 10; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL redir_drop k=%0d: got req=%b addr=%h valid=%b required 1/0/0", k, imem_req, imem_addr, instr_valid);
        end
      end else if (k == 5) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL redir_new k=%0d: got req=%b addr=%h valid=%b required 1/100/0", k, imem_req, imem_addr, instr_valid);
        end
      end else if (k == 9) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
          errors++;
          $display("FAIL redir_data: got valid=%b pc=%h required 1/100", instr_valid, instr_pc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000; exp_addr[3] = 32'h0000_0004;
    ack_delay = 0; rand_ack = 0; stall = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    @(posedge clk); #2 redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(posedge clk); #2 redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr[k]) begin
        errors++;
        $display("FAIL wrap_addr k=%0d: got req=%b addr=%h required 1/%h", k, imem_req, imem_addr, exp_addr[k]);
      end
      checks++;
      if (k == 0 ? (instr_valid !== 1'b0) : (instr_valid !== 1'b1 || instr_pc !== exp_addr[k - 1])) begin
        errors++;
        $display("FAIL wrap_instr k=%0d: got valid=%b pc=%h", k, instr_valid, instr_pc);
      end
    end
  endtask

`ifdef FETCH_ALIGN_CHK_EN
  task automatic test_fault();
    ack_delay = 0; rand_ack = 0; stall = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 redirect = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    checks++;
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_early: got %b required 0", fetch_fault); end
    @(posedge clk); #2 redirect = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fault_halt k=%0d: got fault=%b req=%b valid=%b required 1/0/0", k, fetch_fault, imem_req, instr_valid);
      end
    end
  endtask
`endif

  task automatic test_random();
    int npop;
    rand_ack = 1; stall = 1'b0;
    do_reset();
    npop = 0;
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      @(posedge clk); #2;
      stall    = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
`ifdef FETCH_ALIGN_CHK_EN
      redirect_pc = redirect_pc & ~32'h3;
`endif
      @(negedge clk);
      if (instr_valid && !stall) npop++;
    end
    @(posedge clk); #2 redirect = 1'b0; stall = 1'b0;
    checks++;
    if (npop < 100) begin errors++; $display("FAIL rand_progress: got %0d pops required >= 100", npop); end
    rand_ack = 0;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    #1 reset = 1'b0;
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect();
    test_wrap();
`ifdef FETCH_ALIGN_CHK_EN
    test_fault();
`endif
    test_random();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
